// File: rtl/te_tdc_capture.sv
// ---------------------------------------------------------------------------
// te_tdc_capture
//   Single-shot, counter-based time-to-digital capture stage. It measures, in
//   clk cycles, the interval between a reference start edge and the delayed
//   edge returned by the delay chain. The result is handed to the back-end
//   through a valid/ready handshake.
//
// Ports
//   clk         sampling clock
//   rst         asynchronous reset, active-high
//   arm_i       one-cycle request to start a new measurement (IDLE only)
//   tstart_i    asynchronous reference edge (same edge that launches the chain)
//   tstop_i     asynchronous delayed edge from the delay-chain output
//   armed_o     waiting for the start edge
//   busy_o      armed or counting
//   result_o    measured interval in clk cycles (saturates at MAX)
//   overflow_o  stop edge not seen within MAX cycles
//   valid_o     result available
//   ready_i     consumer accepts the result
// ---------------------------------------------------------------------------
module te_tdc_capture #(
  parameter int COUNT_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm_i,
  input  logic                  tstart_i,
  input  logic                  tstop_i,
  output logic                  armed_o,
  output logic                  busy_o,
  output logic [COUNT_BITS-1:0] result_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam logic [COUNT_BITS-1:0] MaxCount = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COUNTING,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  startSync_q, stopSync_q;
  logic                    startPrev_q, stopPrev_q;
  logic                    startEdge, stopEdge;
  logic [COUNT_BITS-1:0]   cnt_q, cnt_d;
  logic [COUNT_BITS-1:0]   result_q, result_d;
  logic                    overflow_q, overflow_d;

  // Synchronizers and edge history. Both paths share the same depth so the
  // synchronizer latency cancels out of the start/stop difference. The
  // history flops run in every state, so a level left high from an earlier
  // run can never look like a fresh edge later on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      startSync_q <= '0;
      stopSync_q  <= '0;
      startPrev_q <= 1'b0;
      stopPrev_q  <= 1'b0;
    end else begin
      startSync_q <= {startSync_q[SYNC_STAGES-2:0], tstart_i};
      stopSync_q  <= {stopSync_q[SYNC_STAGES-2:0], tstop_i};
      startPrev_q <= startSync_q[SYNC_STAGES-1];
      stopPrev_q  <= stopSync_q[SYNC_STAGES-1];
    end
  end

  assign startEdge = startSync_q[SYNC_STAGES-1] & ~startPrev_q;
  assign stopEdge  = stopSync_q[SYNC_STAGES-1] & ~stopPrev_q;

  // State and measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and datapath update.
  // In COUNTING, cnt_q holds k-1 where k is the number of cycles since the
  // start-edge detection, so a stop edge reports cnt_q+1. Once cnt_q reaches
  // MAX the current cycle is k = MAX+1: the measurement saturates there
  // (even if a stop edge coincides) and the counter never wraps.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (startEdge && stopEdge) begin
          result_d   = '0;
          overflow_d = 1'b0;
          state_d    = DONE;
        end else if (startEdge) begin
          cnt_d   = '0;
          state_d = COUNTING;
        end
      end
      COUNTING: begin
        if (cnt_q == MaxCount) begin
          result_d   = MaxCount;
          overflow_d = 1'b1;
          state_d    = DONE;
        end else if (stopEdge) begin
          result_d   = cnt_q + 1'b1;
          overflow_d = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    armed_o = 1'b0;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ARMED: begin
        armed_o = 1'b1;
        busy_o  = 1'b1;
      end
      COUNTING: begin
        busy_o = 1'b1;
      end
      DONE: begin
        valid_o = 1'b1;
      end
      default: begin
        armed_o = 1'b0;
      end
    endcase
  end

  assign result_o   = result_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_te_tdc_capture.sv
// ---------------------------------------------------------------------------
// tb_te_tdc_capture
//   Self-checking bench for te_tdc_capture. Each measurement is described by
//   the interval k (cycles between the tstart and tstop rises) and the
//   expected outcome follows directly from that: result = k with no overflow
//   for k <= MAX, otherwise result = MAX with overflow. valid is expected
//   SYNC_STAGES + min(k, MAX+1) + 1 negedges after tstart is driven.
// ---------------------------------------------------------------------------
module tb_te_tdc_capture;

  localparam int COUNT_BITS  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAX         = (1 << COUNT_BITS) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  arm;
  logic                  tstart;
  logic                  tstop;
  logic                  ready;
  logic                  armed;
  logic                  busy;
  logic [COUNT_BITS-1:0] result;
  logic                  overflow;
  logic                  valid;

  int checkCount = 0;
  int errorCount = 0;

  te_tdc_capture #(
    .COUNT_BITS (COUNT_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm_i     (arm),
    .tstart_i  (tstart),
    .tstop_i   (tstop),
    .armed_o   (armed),
    .busy_o    (busy),
    .result_o  (result),
    .overflow_o(overflow),
    .valid_o   (valid),
    .ready_i   (ready)
  );

  // 10 ns sampling clock.
  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A stray tstop pulse long enough to pass the synchronizer, then enough
  // quiet time for its falling edge to drain out.
  task automatic strayStop();
    tstop = 1'b1;
    idleCycles(3);
    tstop = 1'b0;
    idleCycles(SYNC_STAGES + 2);
  endtask

  // One full measurement. k is the tstart-to-tstop interval in cycles;
  // noStop omits the stop edge. holdCycles is how long ready stays low while
  // arm and tstart are disturbed (ignored when readyHigh keeps ready at 1).
  task automatic applyStimulus(input int k, input bit noStop, input bit stray,
                               input bit readyHigh, input int holdCycles);
    int                    e;
    int                    validAt;
    int                    eff;
    logic                  expOv;
    logic [COUNT_BITS-1:0] expResult;
    expOv     = noStop || (k > MAX);
    expResult = expOv ? COUNT_BITS'(MAX) : COUNT_BITS'(k);
    eff       = expOv ? MAX + 1 : k;

    tstart = 1'b0;
    tstop  = 1'b0;
    arm    = 1'b0;
    ready  = readyHigh;
    idleCycles(SYNC_STAGES + 3);
    checkOutput("idle_busy", busy, 0);

    if (stray) begin
      strayStop();
      checkOutput("stray_idle_armed", armed, 0);
    end

    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    checkOutput("armed", armed, 1);
    checkOutput("busy_armed", busy, 1);

    if (stray) begin
      strayStop();
      checkOutput("armed_after_stray", armed, 1);
    end

    validAt = -1;
    e       = 0;
    while (e < 700) begin
      if (valid === 1'b1 && validAt < 0) begin
        validAt = e;
      end
      if (validAt >= 0 && (noStop || k <= MAX || e > k + SYNC_STAGES + 2)) begin
        break;
      end
      if (e == 0) begin
        tstart = 1'b1;
      end
      if (!noStop && e == k) begin
        tstop = 1'b1;
      end
      @(negedge clk);
      e++;
    end

    checkOutput($sformatf("valid_latency_k%0d", k), validAt, SYNC_STAGES + eff + 1);
    checkOutput("valid", valid, 1);
    checkOutput($sformatf("result_k%0d", k), result, expResult);
    checkOutput($sformatf("overflow_k%0d", k), overflow, expOv);
    checkOutput("busy_done", busy, 0);
    checkOutput("armed_done", armed, 0);

    if (readyHigh) begin
      @(negedge clk);
      checkOutput("valid_single_cycle", valid, 0);
      ready = 1'b0;
    end else begin
      repeat (holdCycles) begin
        arm    = 1'($urandom_range(0, 1));
        tstart = ~tstart;
        @(negedge clk);
        checkOutput("hold_valid", valid, 1);
        checkOutput("hold_result", result, expResult);
        checkOutput("hold_overflow", overflow, expOv);
      end
      arm   = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      checkOutput("valid_after_accept", valid, 0);
    end

    tstart = 1'b0;
    tstop  = 1'b0;
    idleCycles(SYNC_STAGES + 3);
    checkOutput("idle_status", {29'd0, armed, busy, valid}, 0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  k;
    bit  noStop;
    bit  readyHigh;

    rst    = 1'b1;
    arm    = 1'b0;
    tstart = 1'b0;
    tstop  = 1'b0;
    ready  = 1'b0;
    idleCycles(3);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_armed", armed, 0);
    checkOutput("reset_result", result, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst = 1'b0;
    idleCycles(2);

    // Directed cases.
    applyStimulus(10, 1'b0, 1'b0, 1'b0, 3);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 2);
    applyStimulus(290, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(5, 1'b0, 1'b1, 1'b0, 2);
    applyStimulus(12, 1'b0, 1'b0, 1'b0, 20);
    applyStimulus(3, 1'b0, 1'b0, 1'b1, 0);
    applyStimulus(MAX, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(MAX - 1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1);

    // Reset in the middle of a count aborts everything at once.
    arm = 1'b1;
    @(negedge clk);
    arm    = 1'b0;
    tstart = 1'b1;
    idleCycles(SYNC_STAGES + 41);
    checkOutput("busy_before_reset", busy, 1);
    rst    = 1'b1;
    tstart = 1'b0;
    #1;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_armed", armed, 0);
    checkOutput("midreset_valid", valid, 0);
    checkOutput("midreset_result", result, 0);
    checkOutput("midreset_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(7, 1'b0, 1'b0, 1'b0, 1);

    // Randomized measurements.
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 300);
      if (k == MAX + 1) begin
        k = MAX + 2;
      end
      noStop    = ($urandom_range(0, 7) == 0);
      readyHigh = !noStop && (k <= MAX) && ($urandom_range(0, 2) == 0);
      applyStimulus(k, noStop, 1'($urandom_range(0, 1)), readyHigh,
                    $urandom_range(0, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
